// File: rtl/dmem_bus_ctrl_if.sv
// Data-memory bus between dmem_bus_ctrl and the external 32-bit memory.
// A beat completes on the edge where BusReq and BusAck are both high.
interface dmem_bus_ctrl_if #(
   parameter int BUS_AW = 32
) ();
   logic              p_DMC_BusReq;
   logic              p_DMC_BusWe;
   logic [BUS_AW-1:0] p_DMC_BusAddr;
   logic [3:0]        p_DMC_BusBe;
   logic [31:0]       p_DMC_BusWData;
   logic              p_DMC_BusAck;
   logic [31:0]       p_DMC_BusRData;

   modport master (
      output p_DMC_BusReq,
      output p_DMC_BusWe,
      output p_DMC_BusAddr,
      output p_DMC_BusBe,
      output p_DMC_BusWData,
      input  p_DMC_BusAck,
      input  p_DMC_BusRData
   );

   modport slave (
      input  p_DMC_BusReq,
      input  p_DMC_BusWe,
      input  p_DMC_BusAddr,
      input  p_DMC_BusBe,
      input  p_DMC_BusWData,
      output p_DMC_BusAck,
      output p_DMC_BusRData
   );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory controller: splits doubles into two 32-bit beats,
// steers byte lanes and stalls the pipeline until the access completes.
module dmem_bus_ctrl #(
   parameter int WIDTH  = 64,
   parameter int BUS_AW = 32
) (
   input  logic             p_DMC_Clk,
   input  logic             p_DMC_Reset,
   input  logic [WIDTH-1:0] p_DMC_Address,
   input  logic [WIDTH-1:0] p_DMC_WriteDataIn,
   input  logic             p_DMC_ReadReq,
   input  logic [3:0]       p_DMC_WriteCtrl,
   input  logic [1:0]       p_DMC_ReadSize,
   output logic [WIDTH-1:0] p_DMC_ReadDataOut,
   output logic             p_DMC_Wait,
   output logic             p_DMC_AlignErr,
   dmem_bus_ctrl_if.master  bus
);
   typedef enum logic [1:0] {
      IDLE,
      BEAT0,
      BEAT1,
      DONE
   } stateE;

   stateE state;
   stateE nextState;

   logic              req;
   logic              weIn;
   logic              misIn;
   logic [1:0]        sizeIn;
   logic [BUS_AW-1:0] addrQ;
   logic [1:0]        sizeQ;
   logic              weQ;
   logic              misQ;
   logic [WIDTH-1:0]  dataQ;
   logic [31:0]       lowWord;
   logic [WIDTH-1:0]  readData;
   logic              isDbl;
   logic              hiBeat;
   logic [BUS_AW-1:0] beatAddr;
   logic [3:0]        beatBe;
   logic [31:0]       beatData;
   logic [7:0]        loadByte;
   logic [15:0]       loadHalf;
   logic [WIDTH-1:0]  loadVal;
   logic              unusedBits;

   // Write wins when both read and write are requested.
   assign weIn   = p_DMC_WriteCtrl[0];
   assign req    = p_DMC_ReadReq | weIn;
   assign sizeIn = weIn ? p_DMC_WriteCtrl[2:1] : p_DMC_ReadSize;
   assign isDbl  = (sizeQ == 2'b11);
   assign hiBeat = (state == BEAT1);

   assign p_DMC_ReadDataOut = readData;
   assign unusedBits = ^{p_DMC_Address[WIDTH-1:BUS_AW],
                         p_DMC_WriteCtrl[3]};

   always_comb begin
      misIn = 1'b0;
      unique case (sizeIn)
         2'b00: misIn = 1'b0;
         2'b01: misIn = p_DMC_Address[0];
         2'b10: misIn = |p_DMC_Address[1:0];
         2'b11: misIn = |p_DMC_Address[2:0];
      endcase
   end

   always_comb begin
      beatAddr = {addrQ[BUS_AW-1:2], 2'b00};
      beatBe   = 4'b1111;
      beatData = dataQ[31:0];
      unique case (sizeQ)
         2'b00: begin
            beatBe   = 4'b0001 << addrQ[1:0];
            beatData = {24'd0, dataQ[7:0]} << {addrQ[1:0], 3'b000};
         end
         2'b01: begin
            beatBe   = addrQ[1] ? 4'b1100 : 4'b0011;
            beatData = addrQ[1] ? {dataQ[15:0], 16'd0}
                                : {16'd0, dataQ[15:0]};
         end
         2'b10: begin
            beatBe = 4'b1111;
         end
         2'b11: begin
            beatAddr = {addrQ[BUS_AW-1:3], hiBeat, 2'b00};
            beatData = hiBeat ? dataQ[63:32] : dataQ[31:0];
         end
      endcase
   end

   assign loadByte = 8'(bus.p_DMC_BusRData >> {addrQ[1:0], 3'b000});
   assign loadHalf = addrQ[1] ? bus.p_DMC_BusRData[31:16]
                              : bus.p_DMC_BusRData[15:0];

   always_comb begin
      loadVal = '0;
      unique case (sizeQ)
         2'b00: loadVal = WIDTH'(loadByte);
         2'b01: loadVal = WIDTH'(loadHalf);
         2'b10: loadVal = WIDTH'(bus.p_DMC_BusRData);
         2'b11: loadVal = WIDTH'({bus.p_DMC_BusRData, lowWord});
      endcase
   end

   always_ff @(posedge p_DMC_Clk) begin
      if (p_DMC_Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState          = state;
      p_DMC_Wait         = 1'b0;
      p_DMC_AlignErr     = 1'b0;
      bus.p_DMC_BusReq   = 1'b0;
      bus.p_DMC_BusWe    = 1'b0;
      bus.p_DMC_BusAddr  = '0;
      bus.p_DMC_BusBe    = 4'b0000;
      bus.p_DMC_BusWData = 32'd0;
      unique case (state)
         IDLE: begin
            if (req) begin
               p_DMC_Wait = 1'b1;
               nextState  = misIn ? DONE : BEAT0;
            end
         end
         BEAT0, BEAT1: begin
            p_DMC_Wait         = 1'b1;
            bus.p_DMC_BusReq   = 1'b1;
            bus.p_DMC_BusWe    = weQ;
            bus.p_DMC_BusAddr  = beatAddr;
            bus.p_DMC_BusBe    = beatBe;
            bus.p_DMC_BusWData = beatData;
            if (bus.p_DMC_BusAck) begin
               nextState = (!hiBeat && isDbl) ? BEAT1 : DONE;
            end
         end
         DONE: begin
            p_DMC_AlignErr = misQ;
            nextState      = IDLE;
         end
      endcase
      if (p_DMC_Reset) begin
         p_DMC_Wait = 1'b0;
      end
   end

   // Only latched copies are used once the access leaves IDLE.
   always_ff @(posedge p_DMC_Clk) begin
      if (p_DMC_Reset) begin
         addrQ    <= '0;
         sizeQ    <= 2'b00;
         weQ      <= 1'b0;
         misQ     <= 1'b0;
         dataQ    <= '0;
         lowWord  <= 32'd0;
         readData <= '0;
      end else begin
         if (state == IDLE && req) begin
            addrQ <= p_DMC_Address[BUS_AW-1:0];
            sizeQ <= sizeIn;
            weQ   <= weIn;
            misQ  <= misIn;
            dataQ <= p_DMC_WriteDataIn;
            if (misIn && !weIn) begin
               readData <= '0;
            end
         end
         if (bus.p_DMC_BusAck && !weQ) begin
            if (state == BEAT0 && isDbl) begin
               lowWord <= bus.p_DMC_BusRData;
            end else if (state == BEAT0 || state == BEAT1) begin
               readData <= loadVal;
            end
         end
      end
   end
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed scenarios plus random loads/stores
// against a byte-addressed reference memory.
module tb_dmem_bus_ctrl;
   localparam int WIDTH  = 64;
   localparam int BUS_AW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] writeData;
   logic             readReq;
   logic [3:0]       writeCtrl;
   logic [1:0]       readSize;
   logic [WIDTH-1:0] readDataOut;
   logic             waitOut;
   logic             alignErr;

   int nChecks = 0;
   int nPass   = 0;

   bit [7:0] busMem [bit [31:0]];
   bit [7:0] refMem [bit [31:0]];

   int          obsCycles;
   int          obsWaitCycles;
   int          obsAlign;
   int          obsReqCycles;
   bit          obsFirstWait;
   bit          obsDone;
   logic [63:0] obsResult;
   logic [31:0] bAddr [$];
   logic [3:0]  bBe [$];
   logic [31:0] bWd [$];
   logic        bWe [$];

   always #5 clk = ~clk;

   dmem_bus_ctrl_if #(.BUS_AW(BUS_AW)) bus ();

   dmem_bus_ctrl #(
      .WIDTH (WIDTH),
      .BUS_AW(BUS_AW)
   ) dut (
      .p_DMC_Clk        (clk),
      .p_DMC_Reset      (rst),
      .p_DMC_Address    (address),
      .p_DMC_WriteDataIn(writeData),
      .p_DMC_ReadReq    (readReq),
      .p_DMC_WriteCtrl  (writeCtrl),
      .p_DMC_ReadSize   (readSize),
      .p_DMC_ReadDataOut(readDataOut),
      .p_DMC_Wait       (waitOut),
      .p_DMC_AlignErr   (alignErr),
      .bus              (bus)
   );

   function automatic bit [7:0] busByte(input bit [31:0] a);
      return busMem.exists(a) ? busMem[a] : 8'h00;
   endfunction

   function automatic bit [7:0] refByte(input bit [31:0] a);
      return refMem.exists(a) ? refMem[a] : 8'h00;
   endfunction

   function automatic logic [63:0] refLoad(input logic [31:0] a,
                                            input int n);
      logic [63:0] v = 64'd0;
      for (int i = 0; i < n; i++) begin
         v = v | (64'(refByte(a + 32'(i))) << (8 * i));
      end
      return v;
   endfunction

   task automatic seedWord(input bit [31:0] a, input bit [31:0] w);
      for (int i = 0; i < 4; i++) begin
         busMem[a + 32'(i)] = w[8*i +: 8];
      end
   endtask

   // Runs one access with d0/d1 wait cycles before each beat's ack.
   task automatic runAccess(input bit wr, input bit rd,
                            input logic [1:0] sz,
                            input logic [63:0] a,
                            input logic [63:0] wd,
                            input int d0, input int d1);
      int          waited = 0;
      int          beat   = 0;
      int          dly;
      bit          w;
      logic [31:0] ba;
      bAddr.delete();
      bBe.delete();
      bWd.delete();
      bWe.delete();
      obsCycles     = 0;
      obsWaitCycles = 0;
      obsAlign      = 0;
      obsReqCycles  = 0;
      obsDone       = 1'b0;
      obsFirstWait  = 1'b0;
      address   = a;
      writeData = wd;
      readReq   = rd;
      writeCtrl = {1'($urandom), sz, wr};
      readSize  = wr ? 2'($urandom) : sz;
      for (int c = 0; c < 200 && !obsDone; c++) begin
         @(negedge clk);
         w = waitOut;
         if (c == 0) obsFirstWait = w;
         if (w) obsWaitCycles++;
         if (alignErr) obsAlign++;
         bus.p_DMC_BusAck = 1'b0;
         if (bus.p_DMC_BusReq) begin
            obsReqCycles++;
            dly = (beat == 0) ? d0 : d1;
            if (waited >= dly) begin
               ba = bus.p_DMC_BusAddr;
               bus.p_DMC_BusAck   = 1'b1;
               bus.p_DMC_BusRData = {busByte(ba + 3), busByte(ba + 2),
                                     busByte(ba + 1), busByte(ba)};
               bAddr.push_back(ba);
               bBe.push_back(bus.p_DMC_BusBe);
               bWd.push_back(bus.p_DMC_BusWData);
               bWe.push_back(bus.p_DMC_BusWe);
               if (bus.p_DMC_BusWe) begin
                  for (int k = 0; k < 4; k++) begin
                     if (bus.p_DMC_BusBe[k]) begin
                        busMem[ba + 32'(k)] = bus.p_DMC_BusWData[8*k +: 8];
                     end
                  end
               end
               beat++;
               waited = 0;
            end else begin
               waited++;
            end
         end
         obsCycles++;
         if (!w) begin
            obsResult = readDataOut;
            obsDone   = 1'b1;
         end
         @(posedge clk);
         #1;
         bus.p_DMC_BusAck = 1'b0;
      end
      readReq   = 1'b0;
      writeCtrl = 4'b0000;
      nChecks++;
      if (!obsDone) $display("FAIL access_timeout: addr %h no DONE", a);
      else nPass++;
   endtask

   function automatic logic [31:0] qa(input int i);
      return (bAddr.size() > i) ? bAddr[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic test_reset();
      rst       = 1'b1;
      address   = 64'h10;
      writeData = 64'd0;
      readReq   = 1'b1;
      writeCtrl = 4'b0000;
      readSize  = 2'b10;
      bus.p_DMC_BusAck   = 1'b0;
      bus.p_DMC_BusRData = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nChecks++;
      if (waitOut !== 1'b0) $display("FAIL rst_wait: got %b want 0", waitOut);
      else nPass++;
      nChecks++;
      if (bus.p_DMC_BusReq !== 1'b0)
         $display("FAIL rst_busreq: got %b want 0", bus.p_DMC_BusReq);
      else nPass++;
      nChecks++;
      if ({bus.p_DMC_BusWe, bus.p_DMC_BusAddr, bus.p_DMC_BusBe,
           bus.p_DMC_BusWData} !== 69'd0)
         $display("FAIL rst_bus: addr %h be %b wd %h want 0",
                  bus.p_DMC_BusAddr, bus.p_DMC_BusBe, bus.p_DMC_BusWData);
      else nPass++;
      nChecks++;
      if (readDataOut !== 64'd0)
         $display("FAIL rst_rdata: got %h want 0", readDataOut);
      else nPass++;
      nChecks++;
      if (alignErr !== 1'b0) $display("FAIL rst_align: got %b want 0", alignErr);
      else nPass++;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      readReq = 1'b0;
   endtask

   task automatic test_word_load();
      seedWord(32'h1004, 32'hDEAD_BEEF);
      runAccess(1'b0, 1'b1, 2'b10, 64'h1004, 64'd0, 0, 0);
      nChecks++;
      if (bAddr.size() !== 1 || qa(0) !== 32'h1004)
         $display("FAIL word_addr: got %h n=%0d want 00001004", qa(0), bAddr.size());
      else nPass++;
      nChecks++;
      if (bBe.size() != 1 || bBe[0] !== 4'b1111 || bWe[0] !== 1'b0)
         $display("FAIL word_be_we: n=%0d want be 1111 we 0", bBe.size());
      else nPass++;
      nChecks++;
      if (obsResult !== 64'h0000_0000_DEAD_BEEF)
         $display("FAIL word_result: got %h want 00000000deadbeef", obsResult);
      else nPass++;
      nChecks++;
      if (obsCycles !== 3 || obsWaitCycles !== 2)
         $display("FAIL word_latency: got %0d/%0d want 3/2", obsCycles, obsWaitCycles);
      else nPass++;
   endtask

   task automatic test_byte_store();
      runAccess(1'b1, 1'b0, 2'b00, 64'h2003, 64'h1234_5678_9ABC_DEA5, 0, 0);
      nChecks++;
      if (qa(0) !== 32'h2000) $display("FAIL byte_addr: got %h want 00002000", qa(0));
      else nPass++;
      nChecks++;
      if (bBe.size() != 1 || bBe[0] !== 4'b1000 || bWe[0] !== 1'b1)
         $display("FAIL byte_be_we: n=%0d want be 1000 we 1", bBe.size());
      else nPass++;
      nChecks++;
      if (bWd.size() != 1 || bWd[0] !== 32'hA500_0000)
         $display("FAIL byte_wdata: n=%0d want a5000000", bWd.size());
      else nPass++;
   endtask

   task automatic test_double_load();
      seedWord(32'h3000, 32'h1122_3344);
      seedWord(32'h3004, 32'h5566_7788);
      runAccess(1'b0, 1'b1, 2'b11, 64'h3000, 64'd0, 2, 0);
      nChecks++;
      if (bAddr.size() !== 2 || qa(0) !== 32'h3000 || qa(1) !== 32'h3004)
         $display("FAIL dbl_addr: got %h,%h want 3000,3004", qa(0), qa(1));
      else nPass++;
      nChecks++;
      if (obsResult !== 64'h5566_7788_1122_3344)
         $display("FAIL dbl_result: got %h want 5566778811223344", obsResult);
      else nPass++;
      nChecks++;
      if (obsWaitCycles !== 5 || obsCycles !== 6)
         $display("FAIL dbl_latency: got wait %0d total %0d want 5/6",
                  obsWaitCycles, obsCycles);
      else nPass++;
   endtask

   task automatic test_misaligned();
      runAccess(1'b0, 1'b1, 2'b01, 64'h4001, 64'd0, 0, 0);
      nChecks++;
      if (obsReqCycles !== 0) $display("FAIL mis_busreq: got %0d want 0", obsReqCycles);
      else nPass++;
      nChecks++;
      if (obsAlign !== 1) $display("FAIL mis_align: got %0d want 1", obsAlign);
      else nPass++;
      nChecks++;
      if (obsResult !== 64'd0) $display("FAIL mis_result: got %h want 0", obsResult);
      else nPass++;
      nChecks++;
      if (obsCycles !== 2) $display("FAIL mis_latency: got %0d want 2", obsCycles);
      else nPass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] stored;
      seedWord(32'h5000, 32'hBEEF_0000);
      runAccess(1'b0, 1'b1, 2'b01, 64'h5002, 64'd0, 0, 0);
      nChecks++;
      if (obsResult !== 64'h0000_0000_0000_BEEF || bAddr.size() != 1)
         $display("FAIL b2b_load: got %h n=%0d want beef n=1", obsResult, bAddr.size());
      else nPass++;
      runAccess(1'b1, 1'b0, 2'b10, 64'h5008, 64'h0000_0000_CAFE_F00D, 1, 0);
      nChecks++;
      if (obsFirstWait !== 1'b1) $display("FAIL b2b_nogap: got %b want 1", obsFirstWait);
      else nPass++;
      nChecks++;
      if (bAddr.size() !== 1 || obsReqCycles !== 2)
         $display("FAIL b2b_beats: got %0d beats %0d req want 1/2",
                  bAddr.size(), obsReqCycles);
      else nPass++;
      nChecks++;
      if (obsResult !== 64'h0000_0000_0000_BEEF)
         $display("FAIL b2b_hold: got %h want beef", obsResult);
      else nPass++;
      stored = {busByte(32'h500B), busByte(32'h500A),
                busByte(32'h5009), busByte(32'h5008)};
      nChecks++;
      if (stored !== 32'hCAFE_F00D) $display("FAIL b2b_mem: got %h want cafef00d", stored);
      else nPass++;
   endtask

   task automatic test_reset_mid();
      address   = 64'h6000;
      writeData = 64'h0123_4567_89AB_CDEF;
      readReq   = 1'b0;
      writeCtrl = 4'b0111;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.p_DMC_BusAck = 1'b1;
      @(posedge clk);
      #1;
      bus.p_DMC_BusAck = 1'b0;
      @(negedge clk);
      nChecks++;
      if (bus.p_DMC_BusReq !== 1'b1 || bus.p_DMC_BusAddr !== 32'h6004)
         $display("FAIL rmid_beat1: req %b addr %h want 1 6004",
                  bus.p_DMC_BusReq, bus.p_DMC_BusAddr);
      else nPass++;
      rst = 1'b1;
      bus.p_DMC_BusAck = 1'b1;
      #1;
      nChecks++;
      if (waitOut !== 1'b0) $display("FAIL rmid_waitforce: got %b want 0", waitOut);
      else nPass++;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      writeCtrl = 4'b0000;
      @(negedge clk);
      nChecks++;
      if ({bus.p_DMC_BusReq, bus.p_DMC_BusWe, bus.p_DMC_BusAddr,
           bus.p_DMC_BusBe, bus.p_DMC_BusWData, waitOut, alignErr} !== 71'd0)
         $display("FAIL rmid_outs: req %b addr %h wait %b want 0",
                  bus.p_DMC_BusReq, bus.p_DMC_BusAddr, waitOut);
      else nPass++;
      nChecks++;
      if (readDataOut !== 64'd0) $display("FAIL rmid_rdata: got %h want 0", readDataOut);
      else nPass++;
      @(posedge clk);
      #1;
      bus.p_DMC_BusAck = 1'b0;
      @(negedge clk);
      nChecks++;
      if (bus.p_DMC_BusReq !== 1'b0 || waitOut !== 1'b0)
         $display("FAIL rmid_lateack: req %b wait %b want 0 0",
                  bus.p_DMC_BusReq, waitOut);
      else nPass++;
   endtask

   task automatic test_random();
      bit          wr;
      bit          rd;
      logic [1:0]  sz;
      int          n;
      logic [63:0] a;
      logic [63:0] wd;
      int          d0;
      int          d1;
      bit          mis;
      int          expBeats;
      int          expCycles;
      logic [63:0] expRes;
      logic [63:0] lastLoad = readDataOut;
      int          bad = 0;
      @(posedge clk);
      #1;
      for (int t = 0; t < 80; t++) begin
         wr = 1'($urandom);
         rd = wr ? 1'($urandom) : 1'b1;
         sz = 2'($urandom);
         n  = 1 << sz;
         a  = 64'h8000 + 64'($urandom_range(0, 127));
         if ($urandom_range(0, 7) != 0) a = a - (a % n);
         mis = (a % n) != 0;
         wd  = {$urandom, $urandom};
         d0  = $urandom_range(0, 3);
         d1  = $urandom_range(0, 3);
         expBeats  = mis ? 0 : (sz == 2'b11 ? 2 : 1);
         expCycles = mis ? 2 : 2 + expBeats + d0 + (sz == 2'b11 ? d1 : 0);
         if (!wr) begin
            expRes   = mis ? 64'd0 : refLoad(a[31:0], n);
            lastLoad = expRes;
         end else begin
            expRes = lastLoad;
         end
         runAccess(wr, rd, sz, a, wd, d0, d1);
         if (wr && !mis) begin
            for (int i = 0; i < n; i++) begin
               refMem[a[31:0] + 32'(i)] = wd[8*i +: 8];
            end
         end
         nChecks++;
         if (obsResult !== expRes)
            $display("FAIL rnd_result[%0d]: got %h want %h", t, obsResult, expRes);
         else nPass++;
         nChecks++;
         if (bAddr.size() !== expBeats || obsCycles !== expCycles)
            $display("FAIL rnd_timing[%0d]: beats %0d cyc %0d want %0d %0d",
                     t, bAddr.size(), obsCycles, expBeats, expCycles);
         else nPass++;
         nChecks++;
         if (obsAlign !== int'(mis))
            $display("FAIL rnd_align[%0d]: got %0d want %0d", t, obsAlign, mis);
         else nPass++;
      end
      for (int i = 32'h8000; i < 32'h8090; i++) begin
         if (busByte(32'(i)) !== refByte(32'(i))) bad++;
      end
      nChecks++;
      if (bad !== 0) $display("FAIL rnd_memory: got %0d bad bytes want 0", bad);
      else nPass++;
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_store();
      test_double_load();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
